// File: rtl/aska_spi_cfg_slave_pkg.sv
// rtl/aska_spi_cfg_slave_pkg.sv - shared constants for the ASKA SPI configuration slave
package aska_spi_cfg_slave_pkg;

    localparam int BITCNT_W    = 6;
    localparam int RD_FLAG_BIT = 7;
    localparam logic [BITCNT_W-1:0] FRAME_BITS = 6'd40;

    localparam logic [1:0] ADDR_CONF0 = 2'd0;
    localparam logic [1:0] ADDR_CONF1 = 2'd1;
    localparam logic [1:0] ADDR_ELE1  = 2'd2;
    localparam logic [1:0] ADDR_ELE2  = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_FULL = 2'd3;

    localparam int CONF0_FREQ_LSB  = 0;
    localparam int CONF0_AMP_LSB   = 12;
    localparam int CONF0_RAMP_LSB  = 18;
    localparam int CONF0_ON_LSB    = 24;
    localparam int CONF1_RF_LSB    = 0;
    localparam int CONF1_OFF_LSB   = 10;
    localparam int CONF1_EN_BIT    = 20;
    localparam int CONF1_PHASE_LSB = 21;

    // Bit counter stops at a full frame so long frames cannot wrap back into range.
    function automatic logic [BITCNT_W-1:0] bitcnt_inc(input logic [BITCNT_W-1:0] c);
        return (c == FRAME_BITS) ? c : c + BITCNT_W'(1);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-stage pin synchronizer with rise/fall pulses
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;
    logic              prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], din};
            prev <= sync[STAGES-1];
        end
    end

    assign dout = sync[STAGES-1];
    assign rise = dout & ~prev;
    assign fall = ~dout & prev;

endmodule

// File: rtl/aska_spi_cfg_slave.sv
// rtl/aska_spi_cfg_slave.sv - SPI mode-0 slave decoding 40-bit frames into the ASKA config registers
module aska_spi_cfg_slave
    import aska_spi_cfg_slave_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int NUM_REGS    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    input  logic              spi_cs,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic [DATA_W-1:0] conf0,
    output logic [DATA_W-1:0] conf1,
    output logic [DATA_W-1:0] ele1,
    output logic [DATA_W-1:0] ele2,
    output logic              wr_strobe,
    output logic [1:0]        wr_addr,
    output logic              frame_err
);

    localparam logic [BITCNT_W-1:0] ADDR_LAST  = BITCNT_W'(ADDR_W - 1);
    localparam logic [BITCNT_W-1:0] ADDR_DONE  = BITCNT_W'(ADDR_W);
    localparam logic [BITCNT_W-1:0] FRAME_LAST = BITCNT_W'(ADDR_W + DATA_W - 1);
    localparam logic [ADDR_W-2:0]   NUM_REGS_A = (ADDR_W-1)'(NUM_REGS);

    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .reset(reset), .din(spi_clk),
        .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .clk(clk), .reset(reset), .din(spi_cs),
        .dout(cs_s), .rise(cs_rise), .fall(cs_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .reset(reset), .din(spi_mosi),
        .dout(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    logic [1:0]          state;
    logic                armed;
    logic                overrun;
    logic [BITCNT_W-1:0] bitcnt;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W-1:0]   addr_next;
    logic [DATA_W-1:0]   shift;
    logic [DATA_W-1:0]   shadow;
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic                rd_active;
    logic                frame_ok;

    // The address is shifted through the low bits of the data register, so its last bit comes from MOSI directly.
    assign addr_next = {shift[ADDR_W-2:0], mosi_s};
    assign rd_active = (state == ST_DATA) && addr[RD_FLAG_BIT];
    assign frame_ok  = (state == ST_FULL) && !overrun && (addr[ADDR_W-2:0] < NUM_REGS_A);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            armed     <= 1'b0;
            overrun   <= 1'b0;
            bitcnt    <= '0;
            addr      <= '0;
            shift     <= '0;
            shadow    <= '0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            frame_err <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            if (cs_s) armed <= 1'b1;
            if (state == ST_IDLE) begin
                if (cs_fall && armed) begin
                    state   <= ST_ADDR;
                    shift   <= '0;
                    bitcnt  <= '0;
                    overrun <= 1'b0;
                end
            end else if (cs_rise) begin
                state <= ST_IDLE;
                if (frame_ok && !addr[RD_FLAG_BIT]) begin
                    regs[addr[1:0]] <= shift;
                    wr_strobe       <= 1'b1;
                    wr_addr         <= addr[1:0];
                end else if (!frame_ok) begin
                    frame_err <= 1'b1;
                end
            end else if (sclk_rise) begin
                bitcnt <= bitcnt_inc(bitcnt);
                if (state == ST_FULL) begin
                    overrun <= 1'b1;
                end else begin
                    shift <= {shift[DATA_W-2:0], mosi_s};
                    if (state == ST_ADDR && bitcnt == ADDR_LAST) begin
                        state <= ST_DATA;
                        addr  <= addr_next;
                        if (addr_next[RD_FLAG_BIT]) shadow <= regs[addr_next[1:0]];
                    end
                    if (state == ST_DATA && bitcnt == FRAME_LAST) state <= ST_FULL;
                end
            end else if (sclk_fall && rd_active && bitcnt != ADDR_DONE) begin
                // The fall right after the last address bit must not shift: the host has not sampled bit 31 yet.
                shadow <= {shadow[DATA_W-2:0], 1'b0};
            end
        end
    end

    assign spi_miso    = rd_active ? shadow[DATA_W-1] : 1'b0;
    assign spi_miso_oe = armed & ~cs_s;
    assign conf0       = regs[ADDR_CONF0];
    assign conf1       = regs[ADDR_CONF1];
    assign ele1        = regs[ADDR_ELE1];
    assign ele2        = regs[ADDR_ELE2];

endmodule

// File: tb/tb_aska_spi_cfg_slave.sv
// tb/tb_aska_spi_cfg_slave.sv - scoreboard bench for aska_spi_cfg_slave
`timescale 1ns/1ps
module tb_aska_spi_cfg_slave;
    import aska_spi_cfg_slave_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        spi_clk = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_cs = 1'b1;
    logic        spi_miso, spi_miso_oe, wr_strobe, frame_err;
    logic [31:0] conf0, conf1, ele1, ele2;
    logic [1:0]  wr_addr;

    aska_spi_cfg_slave dut (
        .clk(clk), .reset(reset), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_cs(spi_cs),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .conf0(conf0), .conf1(conf1), .ele1(ele1), .ele2(ele2),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .frame_err(frame_err)
    );

    always #20 clk = ~clk;

    typedef struct packed {
        logic        is_err;
        logic [1:0]  a;
        logic [31:0] d;
    } ev_t;

    int          total = 0;
    int          bad = 0;
    ev_t         exp_q[$];
    ev_t         mon_ev;
    logic [31:0] model [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dut_reg(input logic [1:0] a);
        case (a)
            2'd0:    return conf0;
            2'd1:    return conf1;
            2'd2:    return ele1;
            default: return ele2;
        endcase
    endfunction

    // Reference rules: only a complete 40-bit frame to an implemented address is legal.
    task automatic expect_frame(input logic [7:0] a, input logic [31:0] d, input int n);
        ev_t  ev;
        logic impl;
        impl = (a[6:0] < 7'd4);
        if (n == 40 && impl && !a[7]) begin
            ev.is_err = 1'b0; ev.a = a[1:0]; ev.d = d;
            model[a[1:0]] = d;
            exp_q.push_back(ev);
        end else if (!(n == 40 && impl && a[7])) begin
            ev.is_err = 1'b1; ev.a = 2'd0; ev.d = 32'd0;
            exp_q.push_back(ev);
        end
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [31:0] d, input int n, input int rst_at,
                              output logic [31:0] rd, output logic oe_mid);
        logic [63:0] w;
        w = {a, d, 24'($urandom)};
        rd = 32'd0;
        oe_mid = 1'b0;
        spi_cs = 1'b0;
        for (int i = 0; i < n; i++) begin
            spi_mosi = w[63-i];
            #500;
            if (i >= 8 && i < 40) rd[39-i] = spi_miso;
            if (i == 20) oe_mid = spi_miso_oe;
            spi_clk = 1'b1;
            #500;
            spi_clk = 1'b0;
            if (i + 1 == rst_at) begin
                reset = 1'b1;
                #40;
                reset = 1'b0;
                for (int r = 0; r < 4; r++) model[r] = 32'd0;
                chk("reset_conf0", conf0, 32'd0);
                chk("reset_conf1", conf1, 32'd0);
                chk("reset_ele1", ele1, 32'd0);
                chk("reset_ele2", ele2, 32'd0);
                chk("reset_flags", {spi_miso, spi_miso_oe, wr_strobe, frame_err, wr_addr}, 32'd0);
            end
        end
        #500;
        spi_cs = 1'b1;
        #1000;
    endtask

    always @(negedge clk) begin
        if (!reset && (wr_strobe || frame_err)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", {30'd0, wr_strobe, frame_err}, 32'd0);
            end else begin
                mon_ev = exp_q.pop_front();
                if (mon_ev.is_err) begin
                    chk("frame_err_pulse", {30'd0, wr_strobe, frame_err}, 32'd1);
                end else begin
                    chk("wr_strobe_pulse", {30'd0, wr_strobe, frame_err}, 32'd2);
                    chk("wr_addr", {30'd0, wr_addr}, {30'd0, mon_ev.a});
                    chk("committed_value", dut_reg(mon_ev.a), mon_ev.d);
                end
            end
        end
    end

    logic [31:0] rd, c0, c1, d;
    logic [7:0]  a;
    logic        oe_mid;
    int          n, kind;

    initial begin
        for (int r = 0; r < 4; r++) model[r] = 32'd0;
        #7;
        #200;
        chk("reset_state", {conf0 | conf1 | ele1 | ele2}, 32'd0);
        chk("reset_pulses", {28'd0, wr_strobe, frame_err, spi_miso, spi_miso_oe}, 32'd0);
        reset = 1'b0;
        #400;

        expect_frame(8'h02, 32'h00008000, 40); send_frame(8'h02, 32'h00008000, 40, -1, rd, oe_mid);
        expect_frame(8'h03, 32'h00004000, 40); send_frame(8'h03, 32'h00004000, 40, -1, rd, oe_mid);
        chk("t1_ele1", ele1, 32'h00008000);
        chk("t1_ele2", ele2, 32'h00004000);
        chk("t1_conf_zero", conf0 | conf1, 32'd0);

        expect_frame(8'h82, 32'h5A5A5A5A, 40); send_frame(8'h82, 32'h5A5A5A5A, 40, -1, rd, oe_mid);
        chk("t5_readback", rd, 32'h00008000);
        chk("t5_oe_cs_low", {31'd0, oe_mid}, 32'd1);
        chk("t5_oe_cs_high", {31'd0, spi_miso_oe}, 32'd0);

        c0 = (32'd50 << CONF0_ON_LSB) | (32'd50 << CONF0_RAMP_LSB) | (32'd25 << CONF0_AMP_LSB) | (32'd400 << CONF0_FREQ_LSB);
        c1 = (32'd4 << CONF1_PHASE_LSB) | (32'd1 << CONF1_EN_BIT) | (32'd50 << CONF1_OFF_LSB) | (32'd8 << CONF1_RF_LSB);
        expect_frame(8'h00, c0, 40); send_frame(8'h00, c0, 40, -1, rd, oe_mid);
        expect_frame(8'h01, c1, 40); send_frame(8'h01, c1, 40, -1, rd, oe_mid);
        chk("t2_conf0", conf0, 32'h32C99190);
        chk("t2_conf1", conf1, 32'h0090C808);

        expect_frame(8'h01, 32'hFFFFFFFF, 32); send_frame(8'h01, 32'hFFFFFFFF, 32, -1, rd, oe_mid);
        chk("t3_conf1_kept", conf1, 32'h0090C808);
        expect_frame(8'h03, 32'h12345678, 40); send_frame(8'h03, 32'h12345678, 40, -1, rd, oe_mid);

        expect_frame(8'h05, 32'hDEADBEEF, 40); send_frame(8'h05, 32'hDEADBEEF, 40, -1, rd, oe_mid);
        expect_frame(8'h01, 32'hCAFEF00D, 41); send_frame(8'h01, 32'hCAFEF00D, 41, -1, rd, oe_mid);
        chk("t4_conf1_kept", conf1, 32'h0090C808);

        send_frame(8'h02, 32'hA5A5A5A5, 40, 24, rd, oe_mid);
        chk("t6_frame_ignored", ele1, 32'd0);
        expect_frame(8'h02, 32'h0BADCAFE, 40); send_frame(8'h02, 32'h0BADCAFE, 40, -1, rd, oe_mid);

        for (int k = 0; k < 18; k++) begin
            kind = $urandom_range(0, 5);
            a = 8'($urandom_range(0, 3));
            d = $urandom;
            n = 40;
            case (kind)
                2:       a = 8'($urandom_range(4, 127)) | 8'($urandom_range(0, 1) << 7);
                3:       n = $urandom_range(1, 39);
                4:       n = $urandom_range(41, 48);
                5:       a = a | 8'h80;
                default: ;
            endcase
            expect_frame(a, d, n);
            send_frame(a, d, n, -1, rd, oe_mid);
            if (kind == 5) chk("rand_readback", rd, model[a[1:0]]);
        end

        #2000;
        chk("queue_drained", exp_q.size(), 32'd0);
        for (int r = 0; r < 4; r++) chk("final_reg", dut_reg(2'(r)), model[r]);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
